// File: rtl/mem_write_buffer.sv
// Write-side buffer between the datapath bus and the data RAM write port.
// Queues saturated {address, data} entries and issues them to the RAM one per cycle.
module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                in_bus,
  input  logic [ADDR_W-1:0]          addr_in,
  input  logic                       Write,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  output logic                       mem_we,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] buf_addr_q [DEPTH];
  logic [ADDR_W-1:0] buf_addr_d [DEPTH];
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [DATA_W-1:0] buf_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              overflow_q, overflow_d;
  logic              full_s, empty_s, push, pop;
  logic [DATA_W-1:0] sat_data;

  always_comb begin
    full_s   = (count_q == CNT_W'(DEPTH));
    empty_s  = (count_q == '0);
    // Full/empty use the pre-edge count: a same-edge pop never frees room for
    // the push, and a push into an empty queue is not popped on that edge.
    push     = Write && !full_s;
    pop      = mem_ready && !empty_s;
    sat_data = (in_bus[15:8] == 8'h00) ? DATA_W'(in_bus[7:0]) : '1;

    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    overflow_d = overflow_q;

    if (push) begin
      buf_addr_d[wr_ptr_q] = addr_in;
      buf_data_d[wr_ptr_q] = sat_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (Write && full_s) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      mem_addr_d = buf_addr_q[rd_ptr_q];
      mem_data_d = buf_data_q[rd_ptr_q];
      mem_we_d   = 1'b1;
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      overflow_q <= overflow_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign overflow = overflow_q;
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: vector table plus hand-written
// sequences for pointer wrap under simultaneous push/pop and reset mid-drain.
module tb_mem_write_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_bus = '0;
  logic [7:0]  addr_in = '0;
  logic        Write = 1'b0;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        wr;
    logic [15:0] bus;
    logic [7:0]  addr;
    logic        rdy;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [7:0]  e_data;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vq[$];

  mem_write_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .addr_in   (addr_in),
    .Write     (Write),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .count     (count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // driver: apply inputs, take one edge, sample 1 time unit later
  task automatic step(input logic r, input logic w, input logic [15:0] b,
                      input logic [7:0] a, input logic rdy);
    rst       = r;
    Write     = w;
    in_bus    = b;
    addr_in   = a;
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [7:0] a,
                            input logic [7:0] d, input logic [2:0] cnt, input logic ovf);
    chk({tag, ".mem_we"},   16'(mem_we),   16'(we));
    chk({tag, ".mem_addr"}, 16'(mem_addr), 16'(a));
    chk({tag, ".mem_data"}, 16'(mem_data), 16'(d));
    chk({tag, ".count"},    16'(count),    16'(cnt));
    chk({tag, ".full"},     16'(full),     16'(cnt == 3'd4));
    chk({tag, ".empty"},    16'(empty),    16'(cnt == 3'd0));
    chk({tag, ".overflow"}, 16'(overflow), 16'(ovf));
  endtask

  initial begin
    logic [15:0] e;
    // rst wr bus addr rdy | we addr data cnt ovf
    vq.push_back('{1, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 8'h00, 3'd0, 0});
    vq.push_back('{1, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 8'h00, 3'd0, 0});
    // single write
    vq.push_back('{0, 1, 16'h0042, 8'h10, 1, 0, 8'h00, 8'h00, 3'd1, 0});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h10, 8'h42, 3'd0, 0});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 0, 8'h10, 8'h42, 3'd0, 0});
    // saturation with overlapping push/pop
    vq.push_back('{0, 1, 16'h0123, 8'h05, 1, 0, 8'h10, 8'h42, 3'd1, 0});
    vq.push_back('{0, 1, 16'h00FF, 8'h06, 1, 1, 8'h05, 8'hFF, 3'd1, 0});
    vq.push_back('{0, 1, 16'h0000, 8'h07, 1, 1, 8'h06, 8'hFF, 3'd1, 0});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h07, 8'h00, 3'd0, 0});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 0, 0, 8'h07, 8'h00, 3'd0, 0});
    // fill and overflow while RAM not ready
    vq.push_back('{0, 1, 16'h00A1, 8'h01, 0, 0, 8'h07, 8'h00, 3'd1, 0});
    vq.push_back('{0, 1, 16'h00A2, 8'h02, 0, 0, 8'h07, 8'h00, 3'd2, 0});
    vq.push_back('{0, 1, 16'h00A3, 8'h03, 0, 0, 8'h07, 8'h00, 3'd3, 0});
    vq.push_back('{0, 1, 16'h00A4, 8'h04, 0, 0, 8'h07, 8'h00, 3'd4, 0});
    vq.push_back('{0, 1, 16'h00A5, 8'h05, 0, 0, 8'h07, 8'h00, 3'd4, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h01, 8'hA1, 3'd3, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h02, 8'hA2, 3'd2, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h03, 8'hA3, 3'd1, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h04, 8'hA4, 3'd0, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 0, 8'h04, 8'hA4, 3'd0, 1});
    // push while full with a same-edge pop is still dropped
    vq.push_back('{0, 1, 16'h00B1, 8'h11, 0, 0, 8'h04, 8'hA4, 3'd1, 1});
    vq.push_back('{0, 1, 16'h00B2, 8'h12, 0, 0, 8'h04, 8'hA4, 3'd2, 1});
    vq.push_back('{0, 1, 16'h00B3, 8'h13, 0, 0, 8'h04, 8'hA4, 3'd3, 1});
    vq.push_back('{0, 1, 16'h00B4, 8'h14, 0, 0, 8'h04, 8'hA4, 3'd4, 1});
    vq.push_back('{0, 1, 16'h00B5, 8'h15, 1, 1, 8'h11, 8'hB1, 3'd3, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h12, 8'hB2, 3'd2, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h13, 8'hB3, 3'd1, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 1, 8'h14, 8'hB4, 3'd0, 1});
    vq.push_back('{0, 0, 16'h0000, 8'h00, 1, 0, 8'h14, 8'hB4, 3'd0, 1});

    @(negedge clk);
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].wr, vq[i].bus, vq[i].addr, vq[i].rdy);
      check_outs($sformatf("vec%0d", i), vq[i].e_we, vq[i].e_addr, vq[i].e_data,
                 vq[i].e_cnt, vq[i].e_ovf);
    end

    // steady push+pop across several pointer wraps, count held at 2
    step(1, 0, 16'h0000, 8'h00, 0);
    step(0, 1, 16'h0030, 8'h20, 0); exp_q.push_back({8'h20, 8'h30});
    step(0, 1, 16'h0031, 8'h21, 0); exp_q.push_back({8'h21, 8'h31});
    chk("wrap.prefill_count", 16'(count), 16'd2);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 16'h0032 + 16'(i), 8'h22 + 8'(i), 1);
      exp_q.push_back({8'h22 + 8'(i), 8'h32 + 8'(i)});
      e = exp_q.pop_front();
      check_outs($sformatf("wrap%0d", i), 1'b1, e[15:8], e[7:0], 3'd2, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 16'h0000, 8'h00, 1);
      e = exp_q.pop_front();
      check_outs($sformatf("wrap_drain%0d", i), 1'b1, e[15:8], e[7:0], 3'(1 - i), 1'b0);
    end
    chk("wrap.queue_empty", 16'(exp_q.size()), 16'd0);

    // reset mid-drain
    step(0, 1, 16'h0050, 8'h40, 0);
    step(0, 1, 16'h0051, 8'h41, 0);
    step(0, 1, 16'h0052, 8'h42, 0);
    step(0, 0, 16'h0000, 8'h00, 1);
    check_outs("rstdrain.first", 1'b1, 8'h40, 8'h50, 3'd2, 1'b0);
    step(1, 0, 16'h0000, 8'h00, 1);
    check_outs("rstdrain.reset", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 16'h0000, 8'h00, 1);
      check_outs($sformatf("rstdrain.after%0d", i), 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Write-side counterpart of the memory buffer register path: takes 16-bit results from the internal bus with a target address and queues them.
- Writes the queued results into the 8-bit data memory, one byte per cycle.
- Sits between the datapath bus and the data RAM write port, so the processor never stalls on a single write while the RAM is not ready.
- Saturates bus values to 8 bits (downsampled pixel range).

Parameters:
- DEPTH, 4, number of queued {address, data} entries; power of two, minimum 2
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- in_bus  input  16  value to be written, from internal bus
- addr_in  input  ADDR_W  target address, sampled with Write
- Write  input  1  push request; sampled on rising edge
- mem_ready  input  1  RAM can accept a write this cycle
- mem_addr  output  ADDR_W  RAM write address (registered)
- mem_data  output  DATA_W  RAM write data (registered)
- mem_we  output  1  RAM write enable, one-cycle pulse per entry (registered)
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: a Write was dropped while full
- count  output  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (rst=1 at an edge):
  - Read/write pointers and count go to 0.
  - mem_we=0, mem_addr=0, mem_data=0, overflow=0; therefore full=0, empty=1.
  - Queued entries are discarded.
  - rst takes priority over Write and mem_ready in the same cycle, including mid-drain.
- Saturation, applied on push:
  - in_bus[15:8]==0: stored data = in_bus[7:0].
  - Otherwise: stored data = 8'hFF.
  - Address is stored unchanged.
- Push:
  - Write=1 and full=0 at an edge: store {addr_in, saturated data} at the write pointer; pointer +1, wrapping modulo DEPTH.
  - Write=1 and full=1: entry dropped, overflow set to 1; overflow holds until rst.
  - Full is evaluated on the pre-edge count. A same-cycle pop does not make room for the push.
- Pop:
  - At an edge with empty=0 and mem_ready=1: head entry loads into mem_addr/mem_data, mem_we=1 for the following cycle, read pointer +1 (wraps).
  - Otherwise mem_we=0, and mem_addr/mem_data hold their last values.
- Count:
  - Push only: count +1.
  - Pop only: count -1.
  - Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
  - Push into empty with mem_ready=1: no same-edge pop; entry not yet visible. Pop occurs at the next edge.
- Latency: Write sampled at edge k → mem_we high during cycle after edge k+1, if mem_ready=1 at edge k+1.
- Throughput: one write per cycle while mem_ready stays 1.
- mem_ready low: queue holds, order preserved (FIFO), no writes issued.
- Back-to-back writes to the same address are issued in order; no merging.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → mem_we=0, empty=1, full=0, count=0, overflow=0.
- Single write with mem_ready=1: Write, in_bus=16'h0042, addr_in=8'h10 at edge 1 → after edge 2: mem_we=1, mem_addr=8'h10, mem_data=8'h42; after edge 3: mem_we=0, empty=1.
- Saturation: in_bus=16'h0123, addr 8'h05 → mem_data=8'hFF. Then in_bus=16'h00FF → mem_data=8'hFF. Then in_bus=16'h0000 → mem_data=8'h00.
- Fill/overflow with mem_ready=0:
  - Push 5 entries (addr 1..5, data 8'hA1..8'hA5) → count=4, full=1, overflow=1.
  - Raise mem_ready → 4 consecutive mem_we pulses, addr 1,2,3,4, data A1..A4; entry 5 never written; overflow stays 1.
- Simultaneous push/pop and wrap:
  - Keep count at 2 while pushing and draining every cycle for 10 cycles → count stays 2; addresses emerge in push order across pointer wrap.
- Reset mid-drain: 3 entries queued, mem_ready=1, rst asserted after first mem_we → next cycle mem_we=0, empty=1; no further writes.
